// File: rtl/elbeth_alu_arbiter.sv
// elbeth_alu_arbiter: shares one combinational elbeth_alu between the main
// execute pipeline (port 0) and an auxiliary unit (port 1). The granted
// request is muxed onto the ALU inputs. The ALU result is captured into a
// single-entry response buffer that is tagged with the owning requester.
module elbeth_alu_arbiter #(
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   OP_WIDTH    = 4,
    parameter bit                   ROUND_ROBIN = 1'b1,
    // Encoding of OP_ADD. The idle ALU drive uses it, so the ALU never sees X.
    parameter logic [OP_WIDTH-1:0]  OP_ADD      = {OP_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [DATA_WIDTH-1:0] alu_data_a,
    output logic [DATA_WIDTH-1:0] alu_data_b,
    output logic [OP_WIDTH-1:0]   alu_operation,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    buf_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_id_q, rsp_id_d;
    logic                  last_grant_q, last_grant_d;

    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  can_accept_s;
    logic                  accept0_s;
    logic                  accept1_s;

    // Grant selection: a single valid port wins outright; a tie goes to the
    // port that was not served last (round robin) or always to port 0.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01: gnt0_s = 1'b1;
            2'b10: gnt1_s = 1'b1;
            2'b11: begin
                if (ROUND_ROBIN && (last_grant_q == 1'b0)) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b1;
                end
            end
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
    end

    // Handshake: the buffer takes a new result when it is empty or is being
    // drained in this same cycle. Nothing is accepted while in reset.
    always_comb begin
        can_accept_s = (state_q == ST_EMPTY) || rsp_ready;
        req0_ready   = can_accept_s && gnt0_s && !rst;
        req1_ready   = can_accept_s && gnt1_s && !rst;
        accept0_s    = req0_valid && req0_ready;
        accept1_s    = req1_valid && req1_ready;
    end

    // ALU operand/opcode mux; drives a harmless ADD 0,0 when nobody is granted.
    always_comb begin
        alu_data_a    = {DATA_WIDTH{1'b0}};
        alu_data_b    = {DATA_WIDTH{1'b0}};
        alu_operation = OP_ADD;
        if (gnt0_s) begin
            alu_data_a    = req0_a;
            alu_data_b    = req0_b;
            alu_operation = req0_op;
        end else if (gnt1_s) begin
            alu_data_a    = req1_a;
            alu_data_b    = req1_b;
            alu_operation = req1_op;
        end else begin
            alu_data_a    = {DATA_WIDTH{1'b0}};
            alu_data_b    = {DATA_WIDTH{1'b0}};
            alu_operation = OP_ADD;
        end
    end

    // Response buffer next state plus payload and last-grant update.
    always_comb begin
        state_d      = state_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept0_s || accept1_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept0_s || accept1_s) begin
                    state_d = ST_FULL;
                end else if (rsp_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (accept0_s) begin
            rsp_result_d = alu_result;
            rsp_id_d     = 1'b0;
            last_grant_d = 1'b0;
        end else if (accept1_s) begin
            rsp_result_d = alu_result;
            rsp_id_d     = 1'b1;
            last_grant_d = 1'b1;
        end else begin
            rsp_result_d = rsp_result_q;
            rsp_id_d     = rsp_id_q;
            last_grant_d = last_grant_q;
        end
    end

    // State registers; reset empties the buffer and hands port 0 the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            rsp_result_q <= {DATA_WIDTH{1'b0}};
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule
